// File: rtl/song_sequencer_if.sv
// Bus between song_sequencer, its song ROM and note_player.
// The master side is the sequencer: it addresses the ROM and loads notes.
// The slave side is the ROM/note_player pair: it returns data and reports
// note completion.
interface song_sequencer_if #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5
) ();

  logic [SONG_W+IDX_W-1:0] rom_addr;
  logic [11:0]             rom_data;
  logic                    note_done;
  logic [5:0]              note_to_load;
  logic [5:0]              duration_to_load;
  logic                    load_new_note;

  modport master (
    output rom_addr,
    output note_to_load,
    output duration_to_load,
    output load_new_note,
    input  rom_data,
    input  note_done
  );

  modport slave (
    input  rom_addr,
    input  note_to_load,
    input  duration_to_load,
    input  load_new_note,
    output rom_data,
    output note_done
  );

endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM entry by entry and hands each
// {note, duration} to note_player with a one-cycle load strobe. The sequencer
// waits for note_done before it fetches the next entry. A zero duration marks
// the end of a song. Reaching the last index also ends the song.
// play=0 freezes everything. new_song restarts at index 0 of song_sel from
// any state.
module song_sequencer #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              new_song,
  song_sequencer_if.master  bus,
  output logic              song_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_LOAD,
    S_WAIT_NOTE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [SONG_W-1:0] song_reg, song_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [5:0]        note_reg, note_next;
  logic [5:0]        dur_reg, dur_next;
  logic              done_reg, done_next;
  // armed_reg is clear in the first WAIT_NOTE cycle. This masks a note_done
  // that is left over from the previous note.
  logic              armed_reg, armed_next;

  // State and datapath registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      song_reg  <= '0;
      idx_reg   <= '0;
      note_reg  <= '0;
      dur_reg   <= '0;
      done_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      song_reg  <= song_next;
      idx_reg   <= idx_next;
      note_reg  <= note_next;
      dur_reg   <= dur_next;
      done_reg  <= done_next;
      armed_reg <= armed_next;
    end
  end

  // Next-state logic: new_song first, then normal sequencing only while playing
  always_comb begin
    state_next = state_reg;
    song_next  = song_reg;
    idx_next   = idx_reg;
    note_next  = note_reg;
    dur_next   = dur_reg;
    done_next  = 1'b0;
    armed_next = (state_reg == S_WAIT_NOTE);

    if (new_song) begin
      song_next  = song_sel;
      idx_next   = '0;
      state_next = S_FETCH;
    end else if (play) begin
      case (state_reg)
        S_IDLE: begin
          idx_next   = '0;
          state_next = S_FETCH;
        end
        S_FETCH: begin
          state_next = S_WAIT_ROM;
        end
        S_WAIT_ROM: begin
          if (bus.rom_data[5:0] == 6'd0) begin
            done_next  = 1'b1;
            idx_next   = '0;
            state_next = S_IDLE;
          end else begin
            note_next  = bus.rom_data[11:6];
            dur_next   = bus.rom_data[5:0];
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          state_next = S_WAIT_NOTE;
        end
        S_WAIT_NOTE: begin
          if (armed_reg && bus.note_done) begin
            if (idx_reg == IDX_LAST) begin
              done_next  = 1'b1;
              idx_next   = '0;
              state_next = S_IDLE;
            end else begin
              idx_next   = idx_reg + IDX_ONE;
              state_next = S_FETCH;
            end
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: the strobe is suppressed while paused, restarting or in reset
  always_comb begin
    bus.rom_addr         = {song_reg, idx_reg};
    bus.note_to_load     = note_reg;
    bus.duration_to_load = dur_reg;
    bus.load_new_note    = (state_reg == S_LOAD) && play && !new_song && !reset;
    song_done            = done_reg;
    busy                 = (state_reg != S_IDLE);
  end

endmodule
